fact_mmio: RTL and testbench

- Memory-mapped register front end for the factorial accelerator; sits between the SoC data bus and the factorial datapath/control pair.
- Latches the operand n and issues a single-cycle go pulse to the core.
- Tracks the core's done/error handshake, captures the final product and exposes sticky status to software.
- Guards against a hung core with a watchdog.

---
 rtl/fact_mmio_pkg.sv | 21 ++
 rtl/fact_watchdog.sv | 27 ++
 rtl/fact_mmio.sv | 127 ++++++++++++
 tb/tb_fact_mmio.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fact_mmio_pkg.sv
// Shared definitions for the factorial accelerator register front end:
// bus address map, STATUS bit positions and control FSM encoding.
package fact_mmio_pkg;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int STATUS_DONE = 0;
  localparam int STATUS_ERR  = 1;
  localparam int STATUS_BUSY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE1 = 2'd3
  } state_t;

endpackage

// File: rtl/fact_watchdog.sv
// Clearable up-counter guarding the wait for the core; tc flags the last
// allowed cycle (count == TIMEOUT-1).
module fact_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fact_mmio.sv
// Bus register front end for the factorial core: latches n, pulses go,
// waits for the two-cycle done handshake and exposes sticky status/result.
module fact_mmio
  import fact_mmio_pkg::*;
#(
  parameter int N_W     = 4,
  parameter int R_W     = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [1:0]     addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [N_W-1:0] n,
  output logic           go,
  input  logic           core_done,
  input  logic           core_error,
  input  logic [R_W-1:0] core_result
);

  state_t         state_reg;
  logic [N_W-1:0] n_reg;
  logic [R_W-1:0] result_reg;
  logic           done_reg;
  logic           err_reg;
  logic           go_reg;
  logic [31:0]    rdata_reg;
  logic [31:0]    rd_word;
  logic           wd_tc;
  logic           busy;
  logic           n_wr;
  logic           go_wr;
  logic           unused_wdata;

  assign unused_wdata = ^wdata[31:N_W];

  assign busy  = (state_reg != IDLE);
  assign n_wr  = we && (addr == ADDR_N) && !busy;
  assign go_wr = we && (addr == ADDR_GO) && wdata[0] && !busy;

  fact_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (state_reg == START),
    .en  (state_reg == WAIT),
    .tc  (wd_tc)
  );

  // Read mux uses pre-edge register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_N:      rd_word[N_W-1:0] = n_reg;
      ADDR_STATUS: begin
        rd_word[STATUS_DONE] = done_reg;
        rd_word[STATUS_ERR]  = err_reg;
        rd_word[STATUS_BUSY] = busy;
      end
      ADDR_RESULT: rd_word[R_W-1:0] = result_reg;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      n_reg      <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      go_reg     <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rdata_reg <= rd_word;
      go_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (n_wr) begin
            n_reg <= wdata[N_W-1:0];
          end
          if (go_wr) begin
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            go_reg    <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          if (core_error) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            state_reg <= DONE1;
          end else if (wd_tc) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        DONE1: begin
          // Only the second consecutive done cycle carries the final product.
          if (core_done) begin
            result_reg <= core_result;
            done_reg   <= 1'b1;
            state_reg  <= IDLE;
          end else begin
            state_reg <= WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign n     = n_reg;
  assign go    = go_reg;

endmodule

// File: tb/tb_fact_mmio.sv
// Directed bench for fact_mmio with a small behavioural core and a scripted stub.
module tb_fact_mmio;

  localparam logic [1:0] A_N = 2'd0, A_GO = 2'd1, A_ST = 2'd2, A_RES = 2'd3;

  logic        clk, rst, we, go;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata, core_result;
  logic [3:0]  n;
  logic        core_done, core_error;

  logic        use_stub, st_done;
  logic [31:0] st_result;
  logic [2:0]  cnt;
  logic [31:0] fval, rc_result;
  logic        rc_done;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [31:0] v;

  fact_mmio #(.N_W(4), .R_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .n(n), .go(go), .core_done(core_done), .core_error(core_error),
    .core_result(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input logic [3:0] x);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(x); i++) r = r * i;
    return r;
  endfunction

  // Behavioural core: done for two cycles, final product on the second.
  always @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      fval <= '0;
    end else if (go && !use_stub && n <= 4'd12) begin
      cnt  <= 3'd4;
      fval <= fact(n);
    end else if (cnt != 0) begin
      cnt <= cnt - 3'd1;
    end
  end
  assign rc_done     = (cnt == 3'd2) || (cnt == 3'd1);
  assign rc_result   = (cnt == 3'd1) ? fval : 32'hDEAD_BEEF;
  assign core_done   = use_stub ? st_done : rc_done;
  assign core_result = use_stub ? st_result : rc_result;
  assign core_error  = use_stub ? 1'b0 : (go && n > 4'd12);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // All bus tasks start and end at a negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s = 32'h4;
    for (int i = 0; i < 100; i++) begin
      rd(A_ST, s);
      if (!s[2]) break;
    end
    chk(tag, {31'b0, s[2]}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    use_stub = 1'b0; st_done = 1'b0; st_result = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_go", {31'b0, go}, 32'h0);
    chk("reset_n", {28'b0, n}, 32'h0);
    rd(A_ST, v);  chk("reset_status", v, 32'h0);
    rd(A_RES, v); chk("reset_result", v, 32'h0);

    // N=5 with the behavioural core
    wr(A_N, 32'hFFFF_FFF5);
    rd(A_N, v); chk("n5_readback", v, 32'h5);
    chk("n5_port", {28'b0, n}, 32'h5);
    wr(A_GO, 32'h1);
    chk("n5_go_high", {31'b0, go}, 32'h1);
    rd(A_ST, v); chk("n5_busy", v, 32'h4);
    chk("n5_go_low", {31'b0, go}, 32'h0);
    wait_idle("n5_idle");
    rd(A_ST, v);  chk("n5_status", v, 32'h1);
    rd(A_RES, v); chk("n5_result", v, 32'd120);
    rd(A_GO, v);  chk("go_reads_zero", v, 32'h0);

    // N=13 is rejected by the core during START
    wr(A_N, 32'd13);
    wr(A_GO, 32'h1);
    wait_idle("n13_idle");
    rd(A_ST, v);  chk("n13_status", v, 32'h3);
    rd(A_RES, v); chk("n13_result_kept", v, 32'd120);

    // Writes while busy are dropped
    wr(A_N, 32'd6);
    wr(A_GO, 32'h1);
    wr(A_N, 32'd2);
    chk("busy_n_dropped", {28'b0, n}, 32'h6);
    wr(A_GO, 32'h1);
    chk("busy_go_dropped", {31'b0, go}, 32'h0);
    wait_idle("n6_idle");
    rd(A_ST, v);  chk("n6_status", v, 32'h1);
    rd(A_RES, v); chk("n6_result", v, 32'd720);
    rd(A_N, v);   chk("n6_kept", v, 32'h6);

    // Watchdog: stub never answers, TIMEOUT=16
    use_stub = 1'b1; st_done = 1'b0;
    wr(A_GO, 32'h1);
    addr = A_ST;
    for (int k = 1; k <= 17; k++) @(negedge clk);
    chk("wd_still_busy", rdata, 32'h4);
    @(negedge clk);
    chk("wd_timeout", rdata, 32'h3);

    // rst two cycles after GO
    use_stub = 1'b0;
    wr(A_N, 32'd7);
    wr(A_GO, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_go", {31'b0, go}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_n", {28'b0, n}, 32'h0);
    rst = 1'b0;
    rd(A_ST, v);  chk("rst_status", v, 32'h0);
    rd(A_RES, v); chk("rst_result", v, 32'h0);
    wr(A_N, 32'd3);
    wr(A_GO, 32'h1);
    wait_idle("n3_idle");
    rd(A_RES, v); chk("n3_result", v, 32'd6);
    rd(A_ST, v);  chk("n3_status", v, 32'h1);

    // Stub: single done pulse, gap, then two-cycle done with 0xAB
    use_stub = 1'b1; st_done = 1'b0; st_result = 32'h55;
    wr(A_GO, 32'h1);
    @(negedge clk);
    st_done = 1'b1;
    @(negedge clk);
    st_done = 1'b0;
    @(negedge clk);
    st_done = 1'b1; st_result = 32'hAB;
    repeat (2) @(negedge clk);
    st_done = 1'b0;
    rd(A_RES, v); chk("pulse_result", v, 32'hAB);
    rd(A_ST, v);  chk("pulse_status", v, 32'h1);
    st_done = 1'b1; st_result = 32'hCD;
    repeat (3) @(negedge clk);
    st_done = 1'b0;
    rd(A_RES, v); chk("idle_no_capture", v, 32'hAB);

    // Read-only registers ignore writes; same-cycle write/read shows old value
    wr(A_ST, 32'hFFFF_FFFF);
    wr(A_RES, 32'h0);
    rd(A_ST, v);  chk("status_ro", v, 32'h1);
    rd(A_RES, v); chk("result_ro", v, 32'hAB);
    addr = A_N; we = 1'b1; wdata = 32'd9;
    @(negedge clk);
    we = 1'b0;
    chk("rw_same_cycle_old", rdata, 32'h3);
    rd(A_N, v); chk("rw_same_cycle_new", v, 32'h9);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
